// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, bit-counter sizing and the serf state type.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 16;
    localparam int unsigned CNT_W     = 5;

    // Bit-count value that marks a complete frame, and the saturation ceiling.
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(SPI_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        StIdle,
        StActive
    } serf_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer with edge detection on the last two stages.
// The reset value is a parameter so an idle-high line comes out of reset
// without producing a spurious edge.
module spi_sync_edge #(
    parameter logic RstVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Two metastability stages followed by one history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RstVal;
            sync_q <= RstVal;
            hist_q <= RstVal;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    // Edge pulses, one clk wide.
    always_comb begin
        rise = sync_q & ~hist_q;
        fall = ~sync_q & hist_q;
    end

endmodule

// File: rtl/spi_serf.sv
// SPI serf (mode 3: SCLK idles high, sample on rise, shift on fall), 16-bit frames.
// Optional feature: define SPI_SERF_ERR_EN to add the frm_err output, which flags
// frames ended with the wrong number of SCLK rises.
module spi_serf
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 wrt,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rdy,
`ifdef SPI_SERF_ERR_EN
    output logic                 frm_err,
`endif
    input  logic                 clr_rdy
);

    logic ss_rise, ss_fall;
    logic sclk_rise, sclk_fall;

    spi_sync_edge #(
        .RstVal (1'b1)
    ) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(
        .RstVal (1'b1)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // MOSI needs no edge detect; three stages keep it aligned with the SCLK edge pulses.
    logic mosi_meta_q, mosi_sync_q, mosi_hist_q;

    // MOSI synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mosi_hist_q <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
            mosi_hist_q <= mosi_sync_q;
        end
    end

    serf_state_e state_q, state_d;

    logic [SPI_WIDTH-1:0] shft_q, shft_d;
    logic [SPI_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [SPI_WIDTH-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 mosi_smpl_q, mosi_smpl_d;
    logic                 set_pend_q, set_pend_d;
    logic                 rdy_q, rdy_d;

    logic start, sample, shift, finish;
    logic frame_ok;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; SCLK edges only matter inside a frame.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        sample  = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StActive;
                    start   = 1'b1;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                end else begin
                    sample = sclk_rise;
                    // The leading fall before the first rise carries no data.
                    shift  = sclk_fall && (bit_cnt_q != '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        frame_ok    = (bit_cnt_q == FRAME_CNT);
        tx_buf_d    = wrt ? tx_data : tx_buf_q;
        shft_d      = shft_q;
        bit_cnt_d   = bit_cnt_q;
        mosi_smpl_d = mosi_smpl_q;
        rx_d        = rx_q;
        if (start) begin
            // A write in the same clk as the frame start goes straight to the shifter.
            shft_d    = wrt ? tx_data : tx_buf_q;
            bit_cnt_d = '0;
        end
        if (sample) begin
            mosi_smpl_d = mosi_hist_q;
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        if (shift) begin
            shft_d = {shft_q[SPI_WIDTH-2:0], mosi_smpl_q};
        end
        if (finish && frame_ok) begin
            rx_d = {shft_q[SPI_WIDTH-2:0], mosi_smpl_q};
        end
        set_pend_d = finish && frame_ok;
        // Set beats clear.
        rdy_d = set_pend_q ? 1'b1 : (clr_rdy ? 1'b0 : rdy_q);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_q      <= '0;
            tx_buf_q    <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            mosi_smpl_q <= 1'b0;
            set_pend_q  <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            shft_q      <= shft_d;
            tx_buf_q    <= tx_buf_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            mosi_smpl_q <= mosi_smpl_d;
            set_pend_q  <= set_pend_d;
            rdy_q       <= rdy_d;
        end
    end

`ifdef SPI_SERF_ERR_EN
    logic err_q, err_d;

    // Error flag next-state: set on a short or long frame, set beats clear.
    always_comb begin
        err_d = (finish && !frame_ok) ? 1'b1 : (clr_rdy ? 1'b0 : err_q);
    end

    // Frame error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frm_err = err_q;
`endif

    assign MISO    = shft_q[SPI_WIDTH-1];
    assign rx_data = rx_q;
    assign rdy     = rdy_q;

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: directed scenarios plus random frames, checked against a
// frame-level model (words in, words out, flag rules).
module tb_spi_serf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI, MISO;
    logic [15:0] tx_data, rx_data;
    logic        wrt, rdy, clr_rdy;
`ifdef SPI_SERF_ERR_EN
    logic        frm_err;
    logic        err_m;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model state.
    logic [15:0] tx_buf_m;
    logic [15:0] rx_m;
    logic        rdy_m;

    spi_serf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt     (wrt),
        .rx_data (rx_data),
        .rdy     (rdy),
`ifdef SPI_SERF_ERR_EN
        .frm_err (frm_err),
`endif
        .clr_rdy (clr_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wrt(input logic [15:0] d);
        @(negedge clk);
        tx_data = d;
        wrt     = 1'b1;
        @(negedge clk);
        wrt      = 1'b0;
        tx_buf_m = d;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        rdy_m   = 1'b0;
        check("rdy_clr", 16'(rdy), 16'(rdy_m));
`ifdef SPI_SERF_ERR_EN
        err_m = 1'b0;
        check("frm_err_clr", 16'(frm_err), 16'(err_m));
`endif
    endtask

    // One monarch frame of nbits SCLK rises. wrt_bit = -1 writes wdata in the clk the
    // serf sees SS_n fall; 0..nbits-1 writes during that bit's high phase; else no write.
    task automatic do_frame(input logic [15:0] word, input int nbits, input int wrt_bit,
                            input logic [15:0] wdata);
        logic [15:0] got;
        logic [15:0] frame_tx;
        logic [15:0] mask;
        got      = '0;
        frame_tx = tx_buf_m;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = word[15];
        wait_clks(2);
        if (wrt_bit == -1) begin
            tx_data  = wdata;
            wrt      = 1'b1;
            frame_tx = wdata;
            tx_buf_m = wdata;
        end
        @(negedge clk);
        wrt = 1'b0;
        wait_clks(13);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            if (i > 0) MOSI = (i < 16) ? word[15 - i] : 1'b0;
            wait_clks(16);
            if (i < 16) got[15 - i] = MISO;
            SCLK = 1'b1;
            if (i == wrt_bit) begin
                tx_data = wdata;
                wrt     = 1'b1;
                @(negedge clk);
                wrt      = 1'b0;
                tx_buf_m = wdata;
                wait_clks(15);
            end else begin
                wait_clks(16);
            end
        end
        check("rdy_before_end", 16'(rdy), 16'(rdy_m));
        SS_n = 1'b1;
        wait_clks(8);
        if (nbits == 16) begin
            rx_m  = word;
            rdy_m = 1'b1;
        end else begin
`ifdef SPI_SERF_ERR_EN
            err_m = 1'b1;
`endif
        end
        check("rx_data", rx_data, rx_m);
        check("rdy", 16'(rdy), 16'(rdy_m));
`ifdef SPI_SERF_ERR_EN
        check("frm_err", 16'(frm_err), 16'(err_m));
`endif
        if (nbits >= 1 && nbits <= 16) begin
            mask = ~(16'hFFFF >> nbits);
            check("miso_word", got & mask, frame_tx & mask);
        end
        wait_clks(8);
    endtask

    task automatic model_reset();
        tx_buf_m = '0;
        rx_m     = '0;
        rdy_m    = 1'b0;
`ifdef SPI_SERF_ERR_EN
        err_m    = 1'b0;
`endif
    endtask

    initial begin
        logic [15:0] w;
        int          nb;
        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        tx_data = '0;
        wrt     = 1'b0;
        clr_rdy = 1'b0;
        model_reset();
        wait_clks(5);
        check("rst_rx_data", rx_data, 16'h0000);
        check("rst_rdy", 16'(rdy), 16'h0000);
        check("rst_miso", 16'(MISO), 16'h0000);
`ifdef SPI_SERF_ERR_EN
        check("rst_frm_err", 16'(frm_err), 16'h0000);
`endif
        rst_n = 1'b1;
        wait_clks(6);
        check("idle_miso", 16'(MISO), 16'h0000);

        // Basic exchange.
        do_wrt(16'hA5C3);
        do_frame(16'h1234, 16, 99, 16'h0000);

        // Back-to-back frames without clearing rdy.
        do_frame(16'hFFFF, 16, 99, 16'h0000);
        do_frame(16'h0000, 16, 99, 16'h0000);

        // Write during a frame only affects the next one.
        do_clr();
        do_wrt(16'h3C3C);
        do_frame(16'h3C3C, 16, 8, 16'h5555);
        do_frame(16'h6A6A, 16, 99, 16'h0000);

        // Short frame is discarded.
        do_frame(16'h0F0F, 9, 99, 16'h0000);
        do_clr();

        // SCLK activity while idle is ignored.
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b0;
            MOSI = 1'b1;
            wait_clks(16);
            SCLK = 1'b1;
            wait_clks(16);
        end
        check("idle_rdy", 16'(rdy), 16'(rdy_m));
        check("idle_rx", rx_data, rx_m);

        // Reset in the middle of a frame, then a fresh frame.
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b1;
        wait_clks(20);
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b0;
            wait_clks(16);
            SCLK = 1'b1;
            wait_clks(16);
        end
        rst_n = 1'b0;
        wait_clks(2);
        SS_n = 1'b1;
        wait_clks(4);
        model_reset();
        check("midrst_rx", rx_data, rx_m);
        check("midrst_rdy", 16'(rdy), 16'(rdy_m));
        check("midrst_miso", 16'(MISO), 16'h0000);
        rst_n = 1'b1;
        wait_clks(8);
        do_frame(16'h8001, 16, 99, 16'h0000);

        // Write coincident with the synchronized SS_n fall takes the bypass path.
        do_wrt(16'h1111);
        do_frame(16'hC0DE, 16, -1, 16'hBEEF);

        // Random frames, writes, clears and bad lengths.
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(1, 0) == 1) do_wrt(16'($urandom));
            w  = 16'($urandom);
            nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 1)) : 16;
            do_frame(w, nb, 99, 16'h0000);
            if ($urandom_range(1, 0) == 1) do_clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
